// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP controller.
// State encodings follow the conventional 1149.1 values, so the encoding of TLR is 4'hF.
package jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR   = 4'h0,
      EXIT1_DR   = 4'h1,
      SHIFT_DR   = 4'h2,
      PAUSE_DR   = 4'h3,
      SELECT_IR  = 4'h4,
      UPDATE_DR  = 4'h5,
      CAPTURE_DR = 4'h6,
      SELECT_DR  = 4'h7,
      EXIT2_IR   = 4'h8,
      EXIT1_IR   = 4'h9,
      SHIFT_IR   = 4'hA,
      PAUSE_IR   = 4'hB,
      RUN_IDLE   = 4'hC,
      UPDATE_IR  = 4'hD,
      CAPTURE_IR = 4'hE,
      TLR        = 4'hF
   } tap_state_t;

   localparam logic [1:0] IR_CAPTURE   = 2'b01;
   localparam int         IDCODE_WIDTH = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state machine: state register on rising tck, next-state logic on tms, and
// combinational state decodes.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic tck,
   input  logic trst,
   input  logic tms,
   output logic test_logic_reset,
   output logic run_test_idle,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic capture_ir,
   output logic shift_ir,
   output logic update_ir
);

   tap_state_t state_reg;
   tap_state_t state_next;

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         state_reg <= TLR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         TLR:        state_next = tms ? TLR       : RUN_IDLE;
         RUN_IDLE:   state_next = tms ? SELECT_DR : RUN_IDLE;
         SELECT_DR:  state_next = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: state_next = tms ? EXIT1_DR  : SHIFT_DR;
         SHIFT_DR:   state_next = tms ? EXIT1_DR  : SHIFT_DR;
         EXIT1_DR:   state_next = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   state_next = tms ? EXIT2_DR  : PAUSE_DR;
         EXIT2_DR:   state_next = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  state_next = tms ? SELECT_DR : RUN_IDLE;
         SELECT_IR:  state_next = tms ? TLR       : CAPTURE_IR;
         CAPTURE_IR: state_next = tms ? EXIT1_IR  : SHIFT_IR;
         SHIFT_IR:   state_next = tms ? EXIT1_IR  : SHIFT_IR;
         EXIT1_IR:   state_next = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   state_next = tms ? EXIT2_IR  : PAUSE_IR;
         EXIT2_IR:   state_next = tms ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:  state_next = tms ? SELECT_DR : RUN_IDLE;
         default:    state_next = TLR;
      endcase
   end

   always_comb begin
      test_logic_reset = (state_reg == TLR);
      run_test_idle    = (state_reg == RUN_IDLE);
      capture_dr       = (state_reg == CAPTURE_DR);
      shift_dr         = (state_reg == SHIFT_DR);
      update_dr        = (state_reg == UPDATE_DR);
      capture_ir       = (state_reg == CAPTURE_IR);
      shift_ir         = (state_reg == SHIFT_IR);
      update_ir        = (state_reg == UPDATE_IR);
   end

endmodule

// File: rtl/jtag_tap_core.sv
// TAP controller with instruction register, BYPASS and IDCODE registers, user-DR
// select decode and the falling-edge tdo path.
module jtag_tap_core
   import jtag_pkg::*;
#(
   parameter int                  IR_WIDTH      = 4,
   parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
   parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = IR_WIDTH'(4'b0001),
   parameter int                  NUM_USER_DR   = 2,
   parameter logic [IR_WIDTH-1:0] USER_BASE     = IR_WIDTH'(4'b1000)
)
(
   input  logic                   tck,
   input  logic                   trst,
   input  logic                   tms,
   input  logic                   tdi,
   input  logic [NUM_USER_DR-1:0] user_tdo,
   output logic                   tdo,
   output logic                   tdo_en,
   output logic [IR_WIDTH-1:0]    ir,
   output logic [NUM_USER_DR-1:0] user_sel,
   output logic                   capture_dr,
   output logic                   shift_dr,
   output logic                   update_dr,
   output logic                   test_logic_reset,
   output logic                   run_test_idle
);

   logic capture_ir;
   logic shift_ir;
   logic update_ir;

   logic [IR_WIDTH-1:0]     ir_shift_reg;
   logic [IR_WIDTH-1:0]     ir_reg;
   logic                    bypass_reg;
   logic [IDCODE_WIDTH-1:0] idcode_reg;
   logic                    tdo_reg;
   logic                    tdo_en_reg;

   logic                    sel_all_ones;
   logic                    sel_idcode;
   logic                    sel_user;
   logic                    sel_bypass;
   logic [NUM_USER_DR-1:0]  user_hit;
   logic                    dr_tdo;

   jtag_tap_fsm u_fsm (
      .tck              (tck),
      .trst             (trst),
      .tms              (tms),
      .test_logic_reset (test_logic_reset),
      .run_test_idle    (run_test_idle),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .capture_ir       (capture_ir),
      .shift_ir         (shift_ir),
      .update_ir        (update_ir)
   );

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         ir_shift_reg <= '0;
      end else if (capture_ir) begin
         ir_shift_reg <= IR_WIDTH'(IR_CAPTURE);
      end else if (shift_ir) begin
         ir_shift_reg <= {tdi, ir_shift_reg[IR_WIDTH-1:1]};
      end
   end

   // The instruction only moves on the falling edge, so it is stable across a DR scan.
   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         ir_reg <= IDCODE_OPCODE;
      end else if (test_logic_reset) begin
         ir_reg <= IDCODE_OPCODE;
      end else if (update_ir) begin
         ir_reg <= ir_shift_reg;
      end
   end

   assign ir = ir_reg;

   // All-ones and IDCODE take priority over any overlapping user opcode.
   assign sel_all_ones = &ir_reg;
   assign sel_idcode   = !sel_all_ones && (ir_reg == IDCODE_OPCODE);

   for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_user
      assign user_hit[gi] = (ir_reg == IR_WIDTH'(USER_BASE + gi));
   end

   assign user_sel   = (sel_all_ones || sel_idcode) ? '0 : user_hit;
   assign sel_user   = |user_sel;
   assign sel_bypass = !sel_idcode && !sel_user;

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         bypass_reg <= 1'b0;
      end else if (capture_dr && sel_bypass) begin
         bypass_reg <= 1'b0;
      end else if (shift_dr && sel_bypass) begin
         bypass_reg <= tdi;
      end
   end

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         idcode_reg <= '0;
      end else if (capture_dr && sel_idcode) begin
         idcode_reg <= IDCODE_VALUE;
      end else if (shift_dr && sel_idcode) begin
         idcode_reg <= {tdi, idcode_reg[IDCODE_WIDTH-1:1]};
      end
   end

   always_comb begin
      dr_tdo = bypass_reg;
      if (sel_idcode) begin
         dr_tdo = idcode_reg[0];
      end else if (sel_user) begin
         dr_tdo = |(user_sel & user_tdo);
      end
   end

   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         tdo_reg    <= 1'b0;
         tdo_en_reg <= 1'b0;
      end else begin
         tdo_en_reg <= shift_dr || shift_ir;
         if (shift_ir) begin
            tdo_reg <= ir_shift_reg[0];
         end else if (shift_dr) begin
            tdo_reg <= dr_tdo;
         end else begin
            tdo_reg <= 1'b0;
         end
      end
   end

   assign tdo    = tdo_reg;
   assign tdo_en = tdo_en_reg;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: a state-walk vector table plus scan
// sequences whose tdo bits are checked through an expected-value queue.
module tb_jtag_tap_core;

   logic       tck;
   logic       trst;
   logic       tms;
   logic       tdi;
   logic [1:0] user_tdo;
   logic       tdo;
   logic       tdo_en;
   logic [3:0] ir;
   logic [1:0] user_sel;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       test_logic_reset;
   logic       run_test_idle;

   jtag_tap_core dut (
      .tck              (tck),
      .trst             (trst),
      .tms              (tms),
      .tdi              (tdi),
      .user_tdo         (user_tdo),
      .tdo              (tdo),
      .tdo_en           (tdo_en),
      .ir               (ir),
      .user_sel         (user_sel),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .test_logic_reset (test_logic_reset),
      .run_test_idle    (run_test_idle)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_q[$];

   // {tlr, rti, capture_dr, shift_dr, update_dr, tdo_en, tdo}
   logic [6:0] flags;
   assign flags = {test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr, tdo_en, tdo};

   typedef struct {
      logic       tms;
      logic       tdi;
      logic [6:0] flags;
      logic [3:0] ir;
      logic [1:0] usel;
   } vec_t;

   vec_t vecs[23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_tdo(input string name);
      logic e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got tdo=%b with no expected value queued", name, tdo);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(tdo), 32'(e));
      end
   endtask

   // One tck cycle: drive, rising edge, falling edge, then sample 1 ns later.
   task automatic step(input logic tms_v, input logic tdi_v);
      tms = tms_v;
      tdi = tdi_v;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   task automatic load_ir(input logic [3:0] val);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      exp_q.push_back(1'b1);
      step(1'b0, 1'b0);
      check_tdo("ir_capture_lsb");
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            exp_q.push_back(1'b0);
            step(1'b0, val[i]);
            check_tdo("ir_capture_shift");
         end else begin
            step(1'b1, val[i]);
         end
      end
      step(1'b1, 1'b0);
      check("ir_update", 32'(ir), 32'(val));
      step(1'b0, 1'b0);
      $display("ir scan: loaded %b, ir=%b user_sel=%b", val, ir, user_sel);
   endtask

   task automatic read_idcode(input bit do_pause);
      logic [31:0] id_exp;
      logic [31:0] got;
      id_exp = 32'h1000_0001;
      got    = '0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      exp_q.push_back(id_exp[0]);
      step(1'b0, 1'b0);
      got[0] = tdo;
      check_tdo("idcode_bit");
      for (int i = 1; i < 32; i++) begin
         if (do_pause && i == 8) begin
            step(1'b1, 1'b0);
            repeat (10) step(1'b0, 1'b0);
            check("pause_tdo_en", 32'(tdo_en), 32'(0));
            step(1'b1, 1'b0);
         end
         exp_q.push_back(id_exp[i]);
         step(1'b0, 1'b0);
         got[i] = tdo;
         check_tdo("idcode_bit");
      end
      check("idcode_word", got, id_exp);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      $display("idcode read (pause=%0d): 0x%08h", do_pause, got);
   endtask

   task automatic bypass_scan(input logic [3:0] pat);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      exp_q.push_back(1'b0);
      step(1'b0, 1'b0);
      check_tdo("bypass_capture");
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pat[i]);
         step(1'b0, pat[i]);
         check_tdo("bypass_shift");
      end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      $display("bypass scan: tdi pattern %b (lsb first), ir=%b", pat, ir);
   endtask

   task automatic user_scan();
      logic b;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         b = 1'($urandom_range(0, 1));
         user_tdo = {b, ~b};
         exp_q.push_back(b);
         step(1'b0, 1'b0);
         check_tdo("user_tdo_mux");
      end
      user_tdo = 2'b00;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      $display("user scan: 8 bits through user_sel=%b", user_sel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      trst     = 1'b0;
      tms      = 1'b1;
      tdi      = 1'b0;
      user_tdo = 2'b00;

      vecs[0]  = '{1'b0, 1'b0, 7'b0100000, 4'b0001, 2'b00};
      vecs[1]  = '{1'b0, 1'b0, 7'b0100000, 4'b0001, 2'b00};
      vecs[2]  = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[3]  = '{1'b0, 1'b0, 7'b0010000, 4'b0001, 2'b00};
      vecs[4]  = '{1'b0, 1'b0, 7'b0001011, 4'b0001, 2'b00};
      vecs[5]  = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[6]  = '{1'b0, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[7]  = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[8]  = '{1'b0, 1'b0, 7'b0001010, 4'b0001, 2'b00};
      vecs[9]  = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[10] = '{1'b1, 1'b0, 7'b0000100, 4'b0001, 2'b00};
      vecs[11] = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[12] = '{1'b1, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[13] = '{1'b0, 1'b0, 7'b0000000, 4'b0001, 2'b00};
      vecs[14] = '{1'b0, 1'b0, 7'b0000011, 4'b0001, 2'b00};
      vecs[15] = '{1'b1, 1'b1, 7'b0000000, 4'b0001, 2'b00};
      vecs[16] = '{1'b1, 1'b0, 7'b0000000, 4'b1000, 2'b01};
      vecs[17] = '{1'b0, 1'b0, 7'b0100000, 4'b1000, 2'b01};
      vecs[18] = '{1'b1, 1'b0, 7'b0000000, 4'b1000, 2'b01};
      vecs[19] = '{1'b1, 1'b0, 7'b0000000, 4'b1000, 2'b01};
      vecs[20] = '{1'b1, 1'b0, 7'b1000000, 4'b0001, 2'b00};
      vecs[21] = '{1'b1, 1'b0, 7'b1000000, 4'b0001, 2'b00};
      vecs[22] = '{1'b0, 1'b0, 7'b0100000, 4'b0001, 2'b00};

      repeat (2) @(negedge tck);
      #1;
      check("reset_state", 32'({flags, ir, user_sel}), 32'({7'b1000000, 4'b0001, 2'b00}));
      trst = 1'b1;
      step(1'b1, 1'b0);
      check("tlr_hold", 32'(test_logic_reset), 32'(1));

      for (int i = 0; i < 23; i++) begin
         step(vecs[i].tms, vecs[i].tdi);
         check($sformatf("vec%0d", i), 32'({flags, ir, user_sel}),
               32'({vecs[i].flags, vecs[i].ir, vecs[i].usel}));
      end
      $display("state walk: %0d vectors applied", 23);

      read_idcode(1'b0);
      read_idcode(1'b1);

      load_ir(4'hF);
      check("bypass_user_sel", 32'(user_sel), 32'(0));
      bypass_scan(4'b1101);

      load_ir(4'b1001);
      check("user1_sel", 32'(user_sel), 32'(2'b10));
      user_scan();

      load_ir(4'b0101);
      check("undef_user_sel", 32'(user_sel), 32'(0));
      bypass_scan(4'b0110);

      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("in_shift_dr", 32'(shift_dr), 32'(1));
      repeat (5) step(1'b1, 1'b0);
      check("five_tms_tlr", 32'(test_logic_reset), 32'(1));
      check("tlr_ir_reload", 32'(ir), 32'(4'b0001));
      $display("five tms=1 from shift-dr: tlr=%b ir=%b", test_logic_reset, ir);
      step(1'b0, 1'b0);

      load_ir(4'b1001);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("pre_trst_shift_ir", 32'(tdo_en), 32'(1));
      #1;
      trst = 1'b0;
      #1;
      check("trst_async", 32'({test_logic_reset, tdo_en, tdo, ir}), 32'({1'b1, 1'b0, 1'b0, 4'b0001}));
      $display("trst during shift-ir: ir=%b tdo_en=%b tlr=%b", ir, tdo_en, test_logic_reset);
      @(negedge tck);
      #1;
      trst = 1'b1;
      step(1'b0, 1'b0);
      read_idcode(1'b0);

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
